etm_mul_ctrl: RTL

//  Sequencer for the ETM approximate multiplier. Accepts W-bit unsigned operand pairs

---
 rtl/etm_ctrl_pkg.sv | 20 ++
 rtl/etm.sv | 21 ++
 rtl/etm_seq_mul.sv | 47 ++++
 rtl/etm_mul_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/etm_ctrl_pkg.sv
// Shared types for the ETM multiplier sequencer: FSM states, path selection
// and the step-counter width helper.
package etm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        EXACT  = 1'b0,
        APPROX = 1'b1
    } mode_t;

    function automatic int cnt_width(input int s);
        return (s > 1) ? $clog2(s) : 1;
    endfunction

endpackage

// File: rtl/etm.sv
// Combinational ETM non-multiplication part on N-bit operands: from the highest
// bit set in either operand (weighted by 2^N), every lower result bit is forced to 1.
module etm #(
    parameter int N = 8
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] p_o
);

    logic [N-1:0] or_s;

    assign or_s = a_i | b_i;

    for (genvar k = 0; k < N; k++) begin : g_hi
        assign p_o[N+k] = |or_s[N-1:k];
    end

    assign p_o[N-1:0] = {N{|or_s}};

endmodule

// File: rtl/etm_seq_mul.sv
// S x S unsigned shift-add core, one multiplier bit per enabled cycle, LSB first.
// prod_o is the accumulator value after the current step, so done_o and prod_o agree.
module etm_seq_mul #(
    parameter int S = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic           en_i,
    input  logic           last_i,
    input  logic [S-1:0]   a_i,
    input  logic [S-1:0]   b_i,
    output logic           done_o,
    output logic [2*S-1:0] prod_o
);

    logic [2*S-1:0] mcand_r;
    logic [S-1:0]   mplr_r;
    logic [2*S-1:0] acc_r;
    logic [2*S-1:0] acc_next_s;

    assign acc_next_s = acc_r + (mplr_r[0] ? mcand_r : {(2*S){1'b0}});
    assign prod_o     = acc_next_s;
    assign done_o     = en_i & last_i;

    // Operand load on start, one shift-add step per enabled cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_r <= {(2*S){1'b0}};
            mplr_r  <= {S{1'b0}};
            acc_r   <= {(2*S){1'b0}};
        end else if (start_i) begin
            mcand_r <= {{S{1'b0}}, a_i};
            mplr_r  <= b_i;
            acc_r   <= {(2*S){1'b0}};
        end else if (en_i) begin
            mcand_r <= {mcand_r[2*S-2:0], 1'b0};
            mplr_r  <= {1'b0, mplr_r[S-1:1]};
            acc_r   <= acc_next_s;
        end else begin
            mcand_r <= mcand_r;
            mplr_r  <= mplr_r;
            acc_r   <= acc_r;
        end
    end

endmodule

// File: rtl/etm_mul_ctrl.sv
// Sequencer for the ETM approximate multiplier: valid/ready operand intake, exact or
// approximate path selection, fixed S-cycle core run. `ETM_STATS_EN adds accept counters.
module etm_mul_ctrl
    import etm_ctrl_pkg::*;
#(
    parameter int W = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [W-1:0]   x_i,
    input  logic [W-1:0]   y_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [2*W-1:0] p_o,
`ifdef ETM_STATS_EN
    output logic [31:0]    n_exact_o,
    output logic [31:0]    n_approx_o,
`endif
    output logic           approx_o
);

    localparam int S  = W / 2;
    localparam int CW = cnt_width(S);

    state_t         state_r;
    state_t         state_s;
    mode_t          mode_s;
    mode_t          mode_r;
    logic [CW-1:0]  cnt_r;
    logic           accept_s;
    logic           core_en_s;
    logic           last_s;
    logic           core_done_s;
    logic [S-1:0]   op_a_s;
    logic [S-1:0]   op_b_s;
    logic [2*S-1:0] core_prod_s;
    logic [2*S-1:0] etm_s;
    logic [2*S-1:0] etm_lo_r;
    logic [2*W-1:0] p_r;
    logic           approx_r;
    logic           out_valid_r;
    logic           in_ready_r;

    assign last_s = (cnt_r == CW'(S - 1));
    assign mode_s = ((x_i[W-1:S] == {S{1'b0}}) && (y_i[W-1:S] == {S{1'b0}})) ? EXACT : APPROX;
    assign op_a_s = (mode_s == EXACT) ? x_i[S-1:0] : x_i[W-1:S];
    assign op_b_s = (mode_s == EXACT) ? y_i[S-1:0] : y_i[W-1:S];

    etm #(.N(S)) u_etm (
        .a_i (x_i[S-1:0]),
        .b_i (y_i[S-1:0]),
        .p_o (etm_s)
    );

    etm_seq_mul #(.S(S)) u_core (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (accept_s),
        .en_i    (core_en_s),
        .last_i  (last_s),
        .a_i     (op_a_s),
        .b_i     (op_b_s),
        .done_o  (core_done_s),
        .prod_o  (core_prod_s)
    );

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and core control; DONE deliberately never accepts
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        core_en_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid_i) begin
                    accept_s = 1'b1;
                    state_s  = MUL;
                end else begin
                    state_s  = IDLE;
                end
            end
            MUL: begin
                core_en_s = 1'b1;
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = MUL;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Step counter, accept-time capture and registered result/handshake outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r       <= {CW{1'b0}};
            mode_r      <= EXACT;
            etm_lo_r    <= {(2*S){1'b0}};
            p_r         <= {(2*W){1'b0}};
            approx_r    <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            if (core_en_s) begin
                cnt_r <= last_s ? {CW{1'b0}} : cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (accept_s) begin
                mode_r   <= mode_s;
                etm_lo_r <= etm_s;
            end else begin
                mode_r   <= mode_r;
                etm_lo_r <= etm_lo_r;
            end
            if (core_done_s) begin
                p_r      <= (mode_r == EXACT) ? {{(2*W-2*S){1'b0}}, core_prod_s}
                                              : {core_prod_s, etm_lo_r};
                approx_r <= (mode_r == APPROX);
            end else begin
                p_r      <= p_r;
                approx_r <= approx_r;
            end
            out_valid_r <= (state_s == DONE);
            in_ready_r  <= (state_s == IDLE);
        end
    end

    assign p_o         = p_r;
    assign approx_o    = approx_r;
    assign out_valid_o = out_valid_r;
    assign in_ready_o  = in_ready_r;

`ifdef ETM_STATS_EN
    logic [31:0] n_exact_r;
    logic [31:0] n_approx_r;

    // Per-mode accept counters, wrapping naturally at 2^32
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            n_exact_r  <= 32'd0;
            n_approx_r <= 32'd0;
        end else if (accept_s) begin
            n_exact_r  <= (mode_s == EXACT)  ? n_exact_r + 32'd1  : n_exact_r;
            n_approx_r <= (mode_s == APPROX) ? n_approx_r + 32'd1 : n_approx_r;
        end else begin
            n_exact_r  <= n_exact_r;
            n_approx_r <= n_approx_r;
        end
    end

    assign n_exact_o  = n_exact_r;
    assign n_approx_o = n_approx_r;
`endif

endmodule
